// File: rtl/memory_access_unit_if.sv
// rtl/memory_access_unit_if.sv - valid/ready request and response bus between the memory stage and backing memory
interface memory_access_unit_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/memory_access_unit.sv
// rtl/memory_access_unit.sv - RV32I memory stage: cache-hit loads, write-through stores, miss handling; optional MEM_MISALIGN_CHECK_EN
module memory_access_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            ResultSrcM,
  input  logic                  MemWriteM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [2:0]            AddressingControlM,
  input  logic [DATA_WIDTH-1:0] cacheDataM,
  input  logic                  cachehitM,
  memory_access_unit_if.master  mem,
  output logic                  StallM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  MisalignM
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state_q, state_d;
  logic        req_valid_q, req_we_q;
  logic [31:0] req_addr_q, req_wdata_q, rdata_q;
  logic [3:0]  req_wstrb_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic        is_load, is_store, misalign, start;

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] a,
                                         input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  extend = {{24{b[7]}}, b};
      3'b001:  extend = {{16{h[15]}}, h};
      3'b100:  extend = {24'b0, b};
      3'b101:  extend = {16'b0, h};
      default: extend = w;
    endcase
  endfunction

  function automatic logic [3:0] strobe(input logic [1:0] a, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   strobe = 4'b0001 << a;
      2'b01:   strobe = 4'b0011 << {a[1], 1'b0};
      default: strobe = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [31:0] d, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   replicate = {4{d[7:0]}};
      2'b01:   replicate = {2{d[15:0]}};
      default: replicate = d;
    endcase
  endfunction

  assign is_load  = (ResultSrcM == 2'b01);
  assign is_store = MemWriteM;

`ifdef MEM_MISALIGN_CHECK_EN
  // Halfword needs even address, word needs 4-byte alignment; bytes never fault
  assign misalign = (is_load || is_store) &&
                    (((AddressingControlM[1:0] == 2'b01) && ALUResultM[0]) ||
                     ((AddressingControlM[1:0] == 2'b10) && (ALUResultM[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign MisalignM = (state_q == IDLE) && misalign;

  always_comb begin
    state_d   = state_q;
    StallM    = 1'b0;
    ReadDataM = '0;
    start     = 1'b0;
    case (state_q)
      IDLE: begin
        if (misalign) begin
          state_d = IDLE;
        end else if (is_store || (is_load && !cachehitM)) begin
          // Store wins over a simultaneous load flag: every store goes to memory
          StallM  = 1'b1;
          start   = 1'b1;
          state_d = REQ;
        end else if (is_load) begin
          ReadDataM = extend(cacheDataM, ALUResultM[1:0], AddressingControlM);
        end
      end
      REQ: begin
        StallM = 1'b1;
        if (mem.mem_req_ready) state_d = req_we_q ? DONE : RESP;
      end
      RESP: begin
        StallM = 1'b1;
        if (mem.mem_rsp_valid) state_d = DONE;
      end
      DONE: begin
        if (!req_we_q) ReadDataM = extend(rdata_q, addr_lo_q, funct3_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      rdata_q     <= '0;
      funct3_q    <= '0;
      addr_lo_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        req_valid_q <= 1'b1;
        req_we_q    <= is_store;
        req_addr_q  <= {ALUResultM[31:2], 2'b00};
        req_wdata_q <= replicate(WriteDataM, AddressingControlM);
        req_wstrb_q <= is_store ? strobe(ALUResultM[1:0], AddressingControlM) : 4'b0000;
        funct3_q    <= AddressingControlM;
        addr_lo_q   <= ALUResultM[1:0];
      end
      if ((state_q == REQ) && mem.mem_req_ready) req_valid_q <= 1'b0;
      if ((state_q == RESP) && mem.mem_rsp_valid) rdata_q <= mem.mem_rsp_rdata;
    end
  end

  assign mem.mem_req_valid = req_valid_q;
  assign mem.mem_req_we    = req_we_q;
  assign mem.mem_req_addr  = req_addr_q;
  assign mem.mem_req_wdata = req_wdata_q;
  assign mem.mem_req_wstrb = req_wstrb_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// tb/tb_memory_access_unit.sv - directed scoreboard bench for memory_access_unit
module tb_memory_access_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  ResultSrcM;
  logic        MemWriteM;
  logic [31:0] ALUResultM, WriteDataM, cacheDataM, ReadDataM;
  logic [2:0]  AddressingControlM;
  logic        cachehitM, StallM, MisalignM;

  always #5 clk = ~clk;

  memory_access_unit_if bus();

  memory_access_unit dut (
    .clk(clk), .rst_n(rst_n), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .AddressingControlM(AddressingControlM), .cacheDataM(cacheDataM),
    .cachehitM(cachehitM), .mem(bus), .StallM(StallM), .ReadDataM(ReadDataM),
    .MisalignM(MisalignM)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        we;
  } req_t;

  req_t        exp_req[$];
  logic [31:0] exp_rd[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          stalls;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic req_t cur_req();
    return {bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_wstrb, bus.mem_req_we};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] rs, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] f3,
                       input logic [31:0] cache, input logic hit);
    ResultSrcM = rs; MemWriteM = we; ALUResultM = addr; WriteDataM = wd;
    AddressingControlM = f3; cacheDataM = cache; cachehitM = hit;
  endtask

  task automatic idle();
    drive(2'b00, 1'b0, 32'h0, 32'h0, 3'b000, 32'h0, 1'b0);
  endtask

  // Acts as backing memory: ready after rdy_dly valid cycles, response rsp_dly cycles after accept
  task automatic run_txn(input int rdy_dly, input int rsp_dly, input logic [31:0] rdata,
                         output int n_stall);
    int  waited_rdy = 0;
    int  waited_rsp = 0;
    bit  accepted = 0;
    bit  responded = 0;
    n_stall = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      if (bus.mem_req_valid && !accepted) begin
        check("req_expected", 128'(exp_req.size() != 0), 128'(1));
        if (exp_req.size() != 0) check("req_fields", cur_req(), exp_req[0]);
        if (waited_rdy >= rdy_dly) begin
          bus.mem_req_ready = 1'b1;
          accepted = 1'b1;
          if (exp_req.size() != 0) void'(exp_req.pop_front());
        end else begin
          waited_rdy++;
        end
      end else if (accepted && !responded && !bus.mem_req_we) begin
        if (waited_rsp >= rsp_dly) begin
          bus.mem_rsp_valid = 1'b1;
          bus.mem_rsp_rdata = rdata;
          responded = 1'b1;
        end else begin
          waited_rsp++;
        end
      end
      #1;
      if (!StallM) begin
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        return;
      end
      n_stall++;
      @(posedge clk);
      #1;
    end
    check("txn_completed_in_budget", 128'(0), 128'(1));
  endtask

  logic [31:0] hit_addr[6] = '{32'h200, 32'h201, 32'h202, 32'h202, 32'h203, 32'h200};
  logic [2:0]  hit_f3[6]   = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010};
  logic [31:0] hit_exp[6]  = '{32'h0000_0033, 32'h0000_0022, 32'hFFFF_8011,
                               32'h0000_8011, 32'hFFFF_FF80, 32'h8011_2233};

  initial begin
    rst_n = 1'b0;
    idle();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = 32'h0;
    #12;
    check("reset_req", cur_req(), req_t'(0));
    check("reset_valid", bus.mem_req_valid, 0);
    check("reset_outs", {StallM, MisalignM, ReadDataM}, 0);
    step();
    rst_n = 1'b1;
    step();

    // LW hit: same-cycle result, no stall, no request
    drive(2'b01, 1'b0, 32'h200, 32'h0, 3'b010, 32'h8000_00F0, 1'b1);
    exp_rd.push_back(32'h8000_00F0);
    #1;
    check("lw_hit_stall", StallM, 0);
    check("lw_hit_data", ReadDataM, exp_rd.pop_front());
    step();
    check("lw_hit_no_req", bus.mem_req_valid, 0);

    // Hit extraction across lanes and widths
    for (int i = 0; i < 6; i++) begin
      drive(2'b01, 1'b0, hit_addr[i], 32'h0, hit_f3[i], 32'h8011_2233, 1'b1);
      exp_rd.push_back(hit_exp[i]);
      #1;
      check($sformatf("hit_data_%0d", i), ReadDataM, exp_rd.pop_front());
      check($sformatf("hit_stall_%0d", i), StallM, 0);
      step();
    end
    idle();
    step();

    // LB miss 0x103, immediate ready and response
    drive(2'b01, 1'b0, 32'h103, 32'h0, 3'b000, 32'hDEAD_BEEF, 1'b0);
    exp_req.push_back('{addr: 32'h100, wdata: 32'h0, wstrb: 4'b0000, we: 1'b0});
    exp_rd.push_back(32'hFFFF_FF80);
    run_txn(0, 0, 32'h8011_2233, stalls);
    check("lb_miss_stalls", stalls, 3);
    check("lb_miss_data", ReadDataM, exp_rd.pop_front());
    step();
    idle();
    step();

    // LBU miss 0x103, response delayed one cycle
    drive(2'b01, 1'b0, 32'h103, 32'h0, 3'b100, 32'h0, 1'b0);
    exp_req.push_back('{addr: 32'h100, wdata: 32'h0, wstrb: 4'b0000, we: 1'b0});
    exp_rd.push_back(32'h0000_0080);
    run_txn(0, 1, 32'h8011_2233, stalls);
    check("lbu_miss_stalls", stalls, 4);
    check("lbu_miss_data", ReadDataM, exp_rd.pop_front());
    step();
    idle();
    step();

    // SH 0x102, ready held low two cycles
    drive(2'b00, 1'b1, 32'h102, 32'h0000_ABCD, 3'b001, 32'h0, 1'b0);
    exp_req.push_back('{addr: 32'h100, wdata: 32'hABCD_ABCD, wstrb: 4'b1100, we: 1'b1});
    run_txn(2, 0, 32'h0, stalls);
    check("sh_stalls", stalls, 4);
    check("sh_done_data", ReadDataM, 0);
    step();
    idle();
    step();

    // SB 0x201 with load flag and cache hit also set: store must win
    drive(2'b01, 1'b1, 32'h201, 32'h1234_565A, 3'b000, 32'h1111_1111, 1'b1);
    exp_req.push_back('{addr: 32'h200, wdata: 32'h5A5A_5A5A, wstrb: 4'b0010, we: 1'b1});
    run_txn(0, 0, 32'h0, stalls);
    check("sb_prio_stalls", stalls, 2);
    step();
    idle();
    step();

    // SW 0x300
    drive(2'b00, 1'b1, 32'h300, 32'h1234_5678, 3'b010, 32'h0, 1'b0);
    exp_req.push_back('{addr: 32'h300, wdata: 32'h1234_5678, wstrb: 4'b1111, we: 1'b1});
    run_txn(0, 0, 32'h0, stalls);
    check("sw_stalls", stalls, 2);
    step();
    idle();

    // Stray response while idle is ignored
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 32'h5555_5555;
    #1;
    check("stray_rsp_stall", StallM, 0);
    step();
    bus.mem_rsp_valid = 1'b0;
    check("stray_rsp_no_req", bus.mem_req_valid, 0);

    // Reset asserted while waiting in RESP
    drive(2'b01, 1'b0, 32'h400, 32'h0, 3'b010, 32'h0, 1'b0);
    exp_req.push_back('{addr: 32'h400, wdata: 32'h0, wstrb: 4'b0000, we: 1'b0});
    #1;
    check("rst_txn_idle_stall", StallM, 1);
    step();
    check("rst_txn_valid", bus.mem_req_valid, 1);
    check("rst_txn_req", cur_req(), exp_req.pop_front());
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    #1;
    check("rst_txn_resp_stall", StallM, 1);
    idle();
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", bus.mem_req_valid, 0);
    check("rst_async_stall", StallM, 0);
    step();
    rst_n = 1'b1;
    step();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 32'h7777_7777;
    #1;
    check("late_rsp_stall", StallM, 0);
    step();
    bus.mem_rsp_valid = 1'b0;
    check("late_rsp_no_req", bus.mem_req_valid, 0);
    drive(2'b01, 1'b0, 32'h500, 32'h0, 3'b010, 32'h0BAD_F00D, 1'b1);
    exp_rd.push_back(32'h0BAD_F00D);
    #1;
    check("post_rst_hit_data", ReadDataM, exp_rd.pop_front());
    check("post_rst_hit_stall", StallM, 0);
    step();
    idle();
    step();

    // LW at 0x101: faults with the check enabled, otherwise reads word 0x100
    drive(2'b01, 1'b0, 32'h101, 32'h0, 3'b010, 32'h0, 1'b0);
`ifdef MEM_MISALIGN_CHECK_EN
    #1;
    check("misalign_flag", MisalignM, 1);
    check("misalign_stall", StallM, 0);
    check("misalign_data", ReadDataM, 0);
    step();
    check("misalign_no_req", bus.mem_req_valid, 0);
`else
    exp_req.push_back('{addr: 32'h100, wdata: 32'h0, wstrb: 4'b0000, we: 1'b0});
    exp_rd.push_back(32'hCAFE_F00D);
    #1;
    check("unaligned_flag", MisalignM, 0);
    run_txn(0, 0, 32'hCAFE_F00D, stalls);
    check("unaligned_stalls", stalls, 3);
    check("unaligned_data", ReadDataM, exp_rd.pop_front());
    step();
`endif
    idle();
    step();

    check("req_queue_drained", 128'(exp_req.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/memory_access_unit.md
# memory_access_unit

Memory-stage data access unit for the pipelined RV32I core. Consumes the control and data outputs of the EX/MEM pipeline register, serves loads that hit in the data cache with no stall, and runs a valid/ready transaction to backing memory for load misses and every store (write-through). Produces the aligned, sign/zero-extended load result for the MEM/WB register and a stall signal that freezes all upstream stages while a transaction is outstanding.

## Interface
Parameters:
- DATA_WIDTH, 32, data and address width; only 32 is supported
- Reset: one clock; reset is asynchronous and active-low; clock port `clk`, reset port `rst_n`

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- ResultSrcM  in  2  2'b01 marks a load
- MemWriteM  in  1  store request
- ALUResultM  in  32  byte address
- WriteDataM  in  32  store data, right-aligned
- AddressingControlM  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- cacheDataM  in  32  word from cache, valid when cachehitM=1
- cachehitM  in  1  cache hit for current load
- mem_req_valid  out  1  request valid (registered)
- mem_req_ready  in  1  request accepted when valid & ready
- mem_req_we  out  1  1 = write, 0 = read
- mem_req_addr  out  32  word address, {ALUResultM[31:2],2'b00}
- mem_req_wdata  out  32  store data replicated to all lanes
- mem_req_wstrb  out  4  byte enables; 4'b0000 on reads
- mem_rsp_valid  in  1  read data valid, single cycle
- mem_rsp_rdata  in  32  read word
- StallM  out  1  freeze F/D/E/M stages
- ReadDataM  out  32  extended load result
- MisalignM  out  1  misaligned access flag

## Operation
- States: IDLE, REQ, RESP, DONE.
- IDLE: load with cachehitM=1 -> ReadDataM from cacheDataM, StallM=0, stay. Load with cachehitM=0 or MemWriteM=1 -> StallM=1, latch request fields, go REQ. Otherwise StallM=0.
- REQ: mem_req_valid=1, fields held stable; on ready: store -> DONE, load -> RESP. StallM=1.
- RESP: StallM=1; on mem_rsp_valid capture rdata -> DONE.
- DONE: StallM=0, ReadDataM from captured word (loads), -> IDLE. Upstream advances this cycle.
- Extraction: byte lane = addr[1:0], half lane = addr[1]; B/H sign-extend, BU/HU zero-extend, W pass-through.
- wstrb: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111.
- Upstream must hold ALUResultM etc. stable while StallM=1; unit latches them anyway at IDLE exit.
- mem_rsp_valid outside RESP is ignored. Load and store asserted together: store takes priority.

## Timing
- Reset: state IDLE, mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_wdata=0, mem_req_wstrb=0, captured word=0; ReadDataM=0, StallM=0, MisalignM=0 when no access presented.
- Hit load: 0 stall cycles, ReadDataM combinational same cycle.
- Load miss, ready and rsp each immediate: StallM high 3 cycles (IDLE, REQ, RESP), result in DONE.
- Store, ready immediate: StallM high 2 cycles (IDLE, REQ).
- Each cycle ready stays low or rsp absent adds one stall cycle; no timeout.
- Reset mid-transaction: immediate return to IDLE, mem_req_valid drops asynchronously; late response ignored.

## Configuration
- MEM_MISALIGN_CHECK_EN defined: H/HU with addr[0]=1 or W with addr[1:0]!=0 -> MisalignM=1 in IDLE, no request, StallM=0, ReadDataM=0, no write.
- Undefined: MisalignM tied 0; low address bits ignored beyond lane selection, access proceeds normally.

## Test plan
- Load LW hit, cacheDataM=0x8000_00F0 -> same-cycle ReadDataM=0x8000_00F0, StallM=0, no request.
- LB miss addr 0x103, rsp_rdata=0x8011_2233 after ready at cycle 1 -> 3 stall cycles, ReadDataM=0xFFFF_FF80; LBU -> 0x0000_0080.
- SH addr 0x102 data 0x0000_ABCD, ready held low 2 cycles -> wstrb=4'b1100, wdata=0xABCD_ABCD, valid stable, StallM 4 cycles.
- rst_n low during RESP -> IDLE, mem_req_valid=0, StallM=0; subsequent rsp_valid ignored.
- With MEM_MISALIGN_CHECK_EN, LW addr 0x101 -> MisalignM=1, no request; without macro -> normal read of 0x100.
